debug_ocimem_port: RTL
======================

Name: debug_ocimem_port

Overview:
- Consumes the JTAG debug slave's sysclk-domain outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Executes host-requested reads and writes on the CPU's on-chip debug RAM.
- Returns MonDReg, monitor_ready and monitor_error to the JTAG debug slave.
- Also serves the CPU's Avalon debug-memory slave on the same single-port RAM; the JTAG side has priority.

Parameters:
ADDR_W, 8, debug RAM word-address width (RAM depth 2^ADDR_W x 32); legal range 1..9.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
jdo  in  38  JTAG data, already synchronised to clk
take_action_ocimem_a  in  1  one-cycle strobe: address/command load
take_action_ocimem_b  in  1  one-cycle strobe: write data jdo[34:3] at MonAReg
take_no_action_ocimem_a  in  1  one-cycle strobe: read at MonAReg (streaming read)
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  MonDReg holds valid read data
monitor_error  out  1  sticky: JTAG command dropped while busy
avs_address  in  ADDR_W  CPU word address
avs_byteenable  in  4  CPU byte lanes
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_debugaccess  in  1  CPU access is debug-privileged
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  CPU stall

Behaviour:
- Reset values: MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0, avs_waitrequest=1 while reset is asserted, FSM=IDLE. RAM contents are not reset.
- RAM: single port; synchronous read with 1-cycle latency; byte-lane writes.
- jdo fields on take_action_ocimem_a:
  - Address field jdo[16+ADDR_W:17] is loaded into MonAReg.
  - jdo[35]=1 clears monitor_error.
  - jdo[34]=1 also starts a read at the new address.
  - monitor_ready clears on every take_action_ocimem_a.
- take_action_ocimem_b: writes jdo[34:3] to RAM[MonAReg] with all four lanes enabled. MonAReg then increments.
- take_no_action_ocimem_a: starts a read at MonAReg. MonAReg increments when the data lands.
- MonAReg increment wraps modulo 2^ADDR_W: 2^ADDR_W-1 goes to 0.
- JTAG FSM:
  - IDLE: on a read command go to JRD (RAM read issued this cycle). On a write strobe, perform the RAM write this cycle, increment MonAReg, stay in IDLE.
  - JRD: RAM data registered into MonDReg, monitor_ready<=1, MonAReg++, return to IDLE. JTAG read latency is 2 cycles from strobe to monitor_ready.
  - Any take_* strobe arriving while in JRD is dropped and sets monitor_error=1.
  - If more than one strobe is asserted in the same cycle, priority is a > b > no_action_a; the losers are dropped and set monitor_error.
- CPU side:
  - Read: cycle 0 with avs_waitrequest=1, RAM read issued; cycle 1 avs_readdata valid with avs_waitrequest=0.
  - Write: completes in the cycle it is granted, with avs_waitrequest=0.
  - The master holds its request while avs_waitrequest=1.
- Arbitration:
  - A JTAG RAM access (strobe in IDLE, or JRD cycle) owns the port that cycle. A CPU request in that cycle sees avs_waitrequest=1 and is not performed.
  - A CPU read whose issue cycle was granted completes even if a JTAG strobe arrives in its data cycle. RAM data for the CPU is captured that cycle; the JTAG access proceeds.
- avs_waitrequest=1 whenever there is no request (idle-high).
- Reset mid-operation: a pending JRD is abandoned, monitor_ready=0, and a CPU read in progress is aborted.

Optional Feature:
- Macro: DEBUG_OCIMEM_WRITE_PROTECT_EN.
- Defined: a CPU write with avs_debugaccess=0 is acknowledged (avs_waitrequest=0) but does not modify the RAM. CPU reads are unaffected.
- Undefined: avs_debugaccess is ignored, and every granted CPU write updates the RAM.

Test Plan:
- Address/write then read-back:
  - Stimulus: take_action_ocimem_a with address field 0x10 and jdo[34]=0; then take_action_ocimem_b with jdo[34:3]=0xDEADBEEF; then take_action_ocimem_a with address 0x10 and jdo[34]=1.
  - Response: two cycles after the last strobe, monitor_ready=1 and MonDReg=0xDEADBEEF.
- Streaming read with wrap:
  - Stimulus: preload RAM[0xFF]=0x1 and RAM[0]=0x2 (ADDR_W=8); read command at 0xFF; then take_no_action_ocimem_a.
  - Response: MonDReg=0x1, then 0x2; MonAReg=0x01 at the end.
- Collision:
  - Stimulus: CPU avs_read at 0x10 in the same cycle as take_action_ocimem_b.
  - Response: avs_waitrequest=1 that cycle; the JTAG write lands; the CPU read returns the new data with a total latency of 3 cycles.
- Overrun:
  - Stimulus: take_no_action_ocimem_a one cycle after a read command.
  - Response: the second read is dropped and monitor_error=1. take_action_ocimem_a with jdo[35]=1 then clears monitor_error.
- Write protect (macro defined):
  - Stimulus: CPU write 0x12345678 to 0x20 with avs_debugaccess=0, then a read of 0x20.
  - Response: the old value is returned. With avs_debugaccess=1 the read returns 0x12345678.
- Reset during JRD:
  - Stimulus: assert reset in the JRD cycle.
  - Response: monitor_ready=0, MonDReg=0, avs_waitrequest=1; RAM contents are preserved and can be read back after reset is released.

Source files
------------

// File: rtl/debug_ocimem_port.sv
// Debug RAM port: host JTAG reads/writes and CPU Avalon accesses share one single-port RAM.
// Optional DEBUG_OCIMEM_WRITE_PROTECT_EN: CPU writes without avs_debugaccess are acked but dropped.
module debug_ocimem_port #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic {S_IDLE = 1'b0, S_JRD = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [DATA_W-1:0]   mon_d_q, mon_d_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                cpu_pend_q;
  logic [DATA_W-1:0]   avs_rdata_q;
  logic [DATA_W-1:0]   jrd_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                strb_a, strb_b, strb_n;
  logic                jtag_busy, j_we, j_re;
  logic [ADDR_W-1:0]   j_addr, ram_addr;
  logic                cpu_grant, cpu_re, cpu_wr, cpu_we;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifndef DEBUG_OCIMEM_WRITE_PROTECT_EN
  logic unused_dbg;
  assign unused_dbg = avs_debugaccess;
`endif

  assign strb_a = take_action_ocimem_a & ~reset;
  assign strb_b = take_action_ocimem_b & ~reset;
  assign strb_n = take_no_action_ocimem_a & ~reset;

  // JTAG command FSM: strobe priority a > b > no_action; losers and JRD-cycle strobes flag an error
  always_comb begin
    state_d   = state_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    ready_d   = ready_q;
    error_d   = error_q;
    jtag_busy = 1'b0;
    j_we      = 1'b0;
    j_re      = 1'b0;
    j_addr    = mon_a_q;
    case (state_q)
      S_IDLE: begin
        if (strb_a) begin
          jtag_busy = 1'b1;
          mon_a_d   = jdo[16+ADDR_W:17];
          j_addr    = jdo[16+ADDR_W:17];
          ready_d   = 1'b0;
          if (jdo[35]) error_d = 1'b0;
          if (strb_b || strb_n) error_d = 1'b1;
          if (jdo[34]) begin
            j_re    = 1'b1;
            state_d = S_JRD;
          end
        end else if (strb_b) begin
          jtag_busy = 1'b1;
          j_we      = 1'b1;
          mon_a_d   = mon_a_q + ADDR_W'(1);
          if (strb_n) error_d = 1'b1;
        end else if (strb_n) begin
          jtag_busy = 1'b1;
          j_re      = 1'b1;
          state_d   = S_JRD;
        end
      end
      S_JRD: begin
        jtag_busy = 1'b1;
        mon_d_d   = jrd_q;
        ready_d   = 1'b1;
        mon_a_d   = mon_a_q + ADDR_W'(1);
        if (strb_a || strb_b || strb_n) error_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CPU gets the port only when JTAG leaves it free and no read data cycle is in progress
  always_comb begin
    cpu_grant = ~reset & ~jtag_busy & ~cpu_pend_q;
    cpu_re    = cpu_grant & avs_read;
    cpu_wr    = cpu_grant & avs_write & ~avs_read;
`ifdef DEBUG_OCIMEM_WRITE_PROTECT_EN
    cpu_we    = cpu_wr & avs_debugaccess;
`else
    cpu_we    = cpu_wr;
`endif
    ram_addr  = jtag_busy ? j_addr : avs_address;
    avs_waitrequest = ~(cpu_pend_q | cpu_wr);
  end

  always_ff @(posedge clk) begin
    if (j_we) begin
      mem[ram_addr] <= jdo[34:3];
    end else if (cpu_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (avs_byteenable[i]) mem[ram_addr][8*i +: 8] <= avs_writedata[8*i +: 8];
      end
    end
    if (j_re) jrd_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      cpu_pend_q  <= 1'b0;
      avs_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      cpu_pend_q <= cpu_re;
      if (cpu_re) avs_rdata_q <= mem[ram_addr];
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign avs_readdata  = avs_rdata_q;
endmodule
